countdown_timer: RTL

Loadable, prescaled down-counter that consumes a programmed count, decrements it on timed ticks and signals expiry. It is the complement of the team's free-running up-counter: that block produces elapsed time, and this block waits out a requested interval. It sits beside the counter in the timing subsystem and drives event and interrupt lines to control logic. It supports one-shot and periodic (auto-reload) modes, with a sticky interrupt and an overrun flag.

---
 rtl/countdown_timer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable, prescaled down-counter with one-shot and
// periodic (auto-reload) modes, a one-cycle expiry pulse, a sticky irq
// and a sticky overrun flag. All outputs come straight from flops.
module countdown_timer #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  irq_clear,
    output logic [WIDTH-1:0]      value,
    output logic                  running,
    output logic                  expired,
    output logic                  irq,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic [WIDTH-1:0]        reload_reg_q, reload_reg_d;
    logic [PRESCALE_W-1:0]   pc_q, pc_d;
    logic                    irq_q, irq_d;
    logic                    overrun_q, overrun_d;
    logic                    expired_q, expired_d;
    logic                    running_q, running_d;
    logic                    tick;
    logic                    expiry;

    // Next-state logic: request priority stop > load > start, prescaled ticks, expiry and flag handling
    always_comb begin
        state_d      = state_q;
        value_d      = value_q;
        reload_reg_d = reload_reg_q;
        pc_d         = pc_q;
        irq_d        = irq_q;
        overrun_d    = overrun_q;
        expired_d    = 1'b0;
        expiry       = 1'b0;
        tick         = (state_q == RUN) && (pc_q == prescale);

        case (state_q)
            RUN: begin
                if (stop) begin
                    // Abort the count; value is kept so software can inspect it.
                    state_d = IDLE;
                    pc_d    = '0;
                end else begin
                    // A load while running only retargets the next reload.
                    if (load) begin
                        reload_reg_d = load_value;
                    end
                    if (tick) begin
                        pc_d = '0;
                        if (value_q > WIDTH'(1)) begin
                            value_d = value_q - WIDTH'(1);
                        end else if (value_q == WIDTH'(1)) begin
                            // Expiry replaces the 1->0 step, so value never wraps.
                            expiry = 1'b1;
                            if (periodic && (reload_reg_q != '0)) begin
                                value_d = reload_reg_q;
                            end else begin
                                value_d = '0;
                                state_d = DONE;
                            end
                        end
                    end else begin
                        // Free wrap here lets a shrunken prescale roll over and re-compare.
                        pc_d = pc_q + PRESCALE_W'(1);
                    end
                end
            end
            default: begin
                if (load) begin
                    value_d      = load_value;
                    reload_reg_d = load_value;
                    state_d      = IDLE;
                end else if (start && (value_q != '0)) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
        endcase

        if (expiry) begin
            // Setting wins over a coincident clear; overrun only latches if irq was still pending.
            expired_d = 1'b1;
            irq_d     = 1'b1;
            if (irq_q && !irq_clear) begin
                overrun_d = 1'b1;
            end
        end else if (irq_clear) begin
            irq_d     = 1'b0;
            overrun_d = 1'b0;
        end

        running_d = (state_d == RUN);
    end

    // State and registered outputs, cleared asynchronously so a reset aborts any count silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            value_q      <= '0;
            reload_reg_q <= '0;
            pc_q         <= '0;
            irq_q        <= 1'b0;
            overrun_q    <= 1'b0;
            expired_q    <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            reload_reg_q <= reload_reg_d;
            pc_q         <= pc_d;
            irq_q        <= irq_d;
            overrun_q    <= overrun_d;
            expired_q    <= expired_d;
            running_q    <= running_d;
        end
    end

    assign value   = value_q;
    assign running = running_q;
    assign expired = expired_q;
    assign irq     = irq_q;
    assign overrun = overrun_q;

endmodule
